// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared Tomasulo types: func codes, RS classes, ROB tag width, status entries
package tomasulo_pkg;

  localparam int ROB_TAG_W = 3;

  localparam logic [3:0] FUNC_ADD = 4'b0000;
  localparam logic [3:0] FUNC_SUB = 4'b0001;
  localparam logic [3:0] FUNC_MUL = 4'b0010;
  localparam logic [3:0] FUNC_DIV = 4'b0011;
  localparam logic [3:0] FUNC_LD  = 4'b0100;
  localparam logic [3:0] FUNC_ST  = 4'b0101;
  localparam logic [3:0] FUNC_BEQ = 4'b0110;
  localparam logic [3:0] FUNC_BNE = 4'b0111;

  typedef enum logic [1:0] {CLS_ADD, CLS_MUL, CLS_NONE} cls_e;

  typedef struct packed {
    logic                 busy;
    logic [ROB_TAG_W-1:0] tag;
  } status_t;

  typedef struct packed {
    logic [3:0] func;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
  } iq_entry_t;

  function automatic cls_e func_class(input logic [3:0] f);
    case (f)
      FUNC_ADD, FUNC_SUB, FUNC_LD, FUNC_ST, FUNC_BEQ, FUNC_BNE: return CLS_ADD;
      FUNC_MUL, FUNC_DIV: return CLS_MUL;
      default: return CLS_NONE;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [3:0] f);
    return (f == FUNC_ADD) || (f == FUNC_SUB) || (f == FUNC_MUL) ||
           (f == FUNC_DIV) || (f == FUNC_LD);
  endfunction

endpackage

// File: rtl/issue_unit_if.sv
// rtl/issue_unit_if.sv - decoded-instruction input and issued-bundle output of the issue stage
interface issue_unit_if;
  import tomasulo_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_func;
  logic [3:0]           in_rd;
  logic [3:0]           in_rs1;
  logic [3:0]           in_rs2;

  logic                 issue_valid;
  logic [3:0]           func;
  logic [3:0]           rs1;
  logic [3:0]           rs2;
  logic [3:0]           rd;
  logic                 rs1_b;
  logic                 rs2_b;
  logic [ROB_TAG_W-1:0] rob_ind;

  modport master (
    output in_valid, in_func, in_rd, in_rs1, in_rs2,
    input  in_ready, issue_valid, func, rs1, rs2, rd, rs1_b, rs2_b, rob_ind
  );

  modport slave (
    input  in_valid, in_func, in_rd, in_rs1, in_rs2,
    output in_ready, issue_valid, func, rs1, rs2, rd, rs1_b, rs2_b, rob_ind
  );

endinterface

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - in-order instruction FIFO with occupancy count and combinational head
module issue_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             in_ready,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign head     = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign push_ok  = push && in_ready;
  assign pop_ok   = pop && (count_q != '0);

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/issue_unit.sv
// rtl/issue_unit.sv - Tomasulo issue stage: queue, rename via status table, in-order ROB tag allocation.
// ISSUE_BYPASS_EN: a source cleared by a same-cycle commit reads as ready.
module issue_unit
  import tomasulo_pkg::*;
#(
  parameter int IQ_DEPTH  = 4,
  parameter int ROB_DEPTH = 8,
  parameter int NREG      = 16
) (
  input  logic                 clk1,
  input  logic                 rst,
  issue_unit_if.slave          bus,
  input  logic                 add_full,
  input  logic                 mul_full,
  input  logic                 commit_valid,
  input  logic [ROB_TAG_W-1:0] commit_rob,
  input  logic [3:0]           commit_rd,
  input  logic                 flush,
  output logic                 rob_full
);

  localparam int CNT_W    = $clog2(ROB_DEPTH + 1);
  localparam int IQ_CNT_W = $clog2(IQ_DEPTH + 1);

  iq_entry_t             in_entry, head;
  logic [IQ_CNT_W-1:0]   iq_count;
  logic                  iq_ready, push, target_full, do_issue, do_drop;
  logic                  commit_ok, commit_clr;
  cls_e                  cls;
  logic [4:0]            src1, src2;

  status_t               status_q [NREG];
  status_t               status_d [NREG];
  logic [ROB_TAG_W-1:0]  rob_tail_q, rob_tail_d;
  logic [CNT_W-1:0]      rob_count_q, rob_count_d;
  logic                  issue_valid_q, issue_valid_d;
  logic [3:0]            func_q, func_d, rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic                  rs1_b_q, rs1_b_d, rs2_b_q, rs2_b_d;
  logic [ROB_TAG_W-1:0]  rob_ind_q, rob_ind_d;

  assign in_entry = '{func: bus.in_func, rd: bus.in_rd, rs1: bus.in_rs1, rs2: bus.in_rs2};
  assign push     = bus.in_valid && iq_ready && !flush;

  issue_queue #(.DEPTH(IQ_DEPTH), .WIDTH($bits(iq_entry_t))) u_iq (
    .clk1      (clk1),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (in_entry),
    .pop       (do_issue || do_drop),
    .in_ready  (iq_ready),
    .head      (head),
    .count     (iq_count)
  );

  assign cls         = func_class(head.func);
  assign rob_full    = (rob_count_q == CNT_W'(ROB_DEPTH));
  assign target_full = (cls == CLS_ADD) ? add_full : (cls == CLS_MUL) ? mul_full : 1'b0;
  assign do_issue    = (iq_count != '0) && !rob_full && (cls != CLS_NONE) && !target_full && !flush;
  assign do_drop     = (iq_count != '0) && (cls == CLS_NONE) && !flush;
  assign commit_ok   = commit_valid && (rob_count_q != '0);
  assign commit_clr  = commit_ok && status_q[commit_rd].busy && (status_q[commit_rd].tag == commit_rob);

  // Returns {ready, value}: value is the register index when ready, else the zero-extended tag
  function automatic logic [4:0] src_lookup(input logic [3:0] r);
    logic ready;
    ready = !status_q[r].busy;
`ifdef ISSUE_BYPASS_EN
    if (commit_clr && (commit_rd == r)) ready = 1'b1;
`endif
    return ready ? {1'b1, r} : {1'b0, 4'(status_q[r].tag)};
  endfunction

  assign src1 = src_lookup(head.rs1);
  assign src2 = src_lookup(head.rs2);

  always_comb begin
    status_d      = status_q;
    rob_tail_d    = rob_tail_q;
    issue_valid_d = 1'b0;
    func_d        = func_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    rd_d          = rd_q;
    rs1_b_d       = rs1_b_q;
    rs2_b_d       = rs2_b_q;
    rob_ind_d     = rob_ind_q;
    if (commit_clr) status_d[commit_rd] = '0;
    // Applied after the commit clear so a same-cycle rename of commit_rd wins
    if (do_issue) begin
      issue_valid_d = 1'b1;
      func_d        = head.func;
      rd_d          = head.rd;
      {rs1_b_d, rs1_d} = src1;
      {rs2_b_d, rs2_d} = src2;
      rob_ind_d     = rob_tail_q;
      rob_tail_d    = (rob_tail_q == ROB_TAG_W'(ROB_DEPTH - 1)) ? '0 : rob_tail_q + ROB_TAG_W'(1);
      if (writes_rd(head.func)) status_d[head.rd] = '{busy: 1'b1, tag: rob_tail_q};
    end
    rob_count_d = rob_count_q + CNT_W'(do_issue) - CNT_W'(commit_ok);
    if (flush) begin
      for (int i = 0; i < NREG; i++) status_d[i] = '0;
      rob_tail_d    = '0;
      rob_count_d   = '0;
      issue_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) status_q[i] <= '0;
      rob_tail_q    <= '0;
      rob_count_q   <= '0;
      issue_valid_q <= 1'b0;
      func_q        <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      rs1_b_q       <= 1'b0;
      rs2_b_q       <= 1'b0;
      rob_ind_q     <= '0;
    end else begin
      status_q      <= status_d;
      rob_tail_q    <= rob_tail_d;
      rob_count_q   <= rob_count_d;
      issue_valid_q <= issue_valid_d;
      func_q        <= func_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
      rs1_b_q       <= rs1_b_d;
      rs2_b_q       <= rs2_b_d;
      rob_ind_q     <= rob_ind_d;
    end
  end

  assign bus.in_ready    = iq_ready;
  assign bus.issue_valid = issue_valid_q;
  assign bus.func        = func_q;
  assign bus.rs1         = rs1_q;
  assign bus.rs2         = rs2_q;
  assign bus.rd          = rd_q;
  assign bus.rs1_b       = rs1_b_q;
  assign bus.rs2_b       = rs2_b_q;
  assign bus.rob_ind     = rob_ind_q;

endmodule

// File: tb/tb_issue_unit.sv
// tb/tb_issue_unit.sv - table-driven directed bench for issue_unit
module tb_issue_unit;

  logic       clk1 = 1'b0;
  logic       rst  = 1'b1;
  logic       add_full, mul_full, commit_valid, flush, rob_full;
  logic [2:0] commit_rob;
  logic [3:0] commit_rd;

  issue_unit_if bus ();

  issue_unit dut (
    .clk1         (clk1),
    .rst          (rst),
    .bus          (bus),
    .add_full     (add_full),
    .mul_full     (mul_full),
    .commit_valid (commit_valid),
    .commit_rob   (commit_rob),
    .commit_rd    (commit_rd),
    .flush        (flush),
    .rob_full     (rob_full)
  );

  always #5 clk1 = ~clk1;

  typedef struct packed {
    logic       iv;
    logic [3:0] f, rd, r1, r2;
    logic       af, mf, cv;
    logic [2:0] crob;
    logic [3:0] crd;
    logic       fl;
    logic       e_iv;
    logic [3:0] e_f, e_rs1;
    logic       e_b1;
    logic [3:0] e_rs2;
    logic       e_b2;
    logic [3:0] e_rd;
    logic [2:0] e_rob;
    logic       e_rf, e_rdy;
  } vec_t;

  vec_t cur;
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   got;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic ins(input logic [3:0] f, input logic [3:0] rd, input logic [3:0] r1, input logic [3:0] r2);
    cur.iv = 1'b1; cur.f = f; cur.rd = rd; cur.r1 = r1; cur.r2 = r2;
  endtask

  task automatic cmt(input logic [2:0] t, input logic [3:0] r);
    cur.cv = 1'b1; cur.crob = t; cur.crd = r;
  endtask

  task automatic idle(input logic rf, input logic rdy);
    cur.e_iv = 1'b0; cur.e_rf = rf; cur.e_rdy = rdy;
    tbl.push_back(cur);
    cur = '0;
  endtask

  task automatic iss(input logic [3:0] f, input logic [3:0] s1, input logic b1, input logic [3:0] s2,
                     input logic b2, input logic [3:0] rd, input logic [2:0] rob, input logic rf, input logic rdy);
    cur.e_iv = 1'b1; cur.e_f = f; cur.e_rs1 = s1; cur.e_b1 = b1; cur.e_rs2 = s2; cur.e_b2 = b2;
    cur.e_rd = rd; cur.e_rob = rob; cur.e_rf = rf; cur.e_rdy = rdy;
    tbl.push_back(cur);
    cur = '0;
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid = v.iv;  bus.in_func = v.f; bus.in_rd = v.rd; bus.in_rs1 = v.r1; bus.in_rs2 = v.r2;
    add_full = v.af; mul_full = v.mf; commit_valid = v.cv; commit_rob = v.crob; commit_rd = v.crd;
    flush = v.fl;
  endtask

  initial begin
    cur = '0;
    drive(cur);

    // Rename / dependency / commit
    ins(0, 3, 1, 2);             idle(0, 1);
    ins(1, 4, 3, 1);             iss(0, 1, 1, 2, 1, 3, 0, 0, 1);
                                 iss(1, 0, 0, 1, 1, 4, 1, 0, 1);
    cmt(0, 3); ins(2, 5, 3, 3);  idle(0, 1);
                                 iss(2, 3, 1, 3, 1, 5, 2, 0, 1);
    ins(0, 3, 0, 0);             idle(0, 1);
                                 iss(0, 0, 1, 0, 1, 3, 3, 0, 1);
    cmt(5, 3); ins(2, 5, 3, 3);  idle(0, 1);
                                 iss(2, 3, 0, 3, 0, 5, 4, 0, 1);
    // Three queued behind add_full, then flush with an input on the flush cycle
    cur.af = 1; ins(0, 7, 3, 4); idle(0, 1);
    cur.af = 1; ins(0, 8, 1, 1); idle(0, 1);
    cur.af = 1; ins(4, 9, 1, 0); idle(0, 1);
    cur.af = 1; cur.fl = 1; ins(0, 10, 1, 1); idle(0, 1);
    // Fill the ROB through every func class, drop an illegal code
    ins(0, 1, 3, 4);             idle(0, 1);
    ins(2, 2, 5, 6);             iss(0, 3, 1, 4, 1, 1, 0, 0, 1);
    ins(5, 0, 1, 2);             iss(2, 5, 1, 6, 1, 2, 1, 0, 1);
    ins(6, 0, 2, 0);             iss(5, 0, 0, 1, 0, 0, 2, 0, 1);
    ins(8, 7, 0, 0);             iss(6, 1, 0, 0, 1, 0, 3, 0, 1);
    ins(4, 9, 0, 0);             idle(0, 1);
    ins(0, 10, 9, 10);           iss(4, 0, 1, 0, 1, 9, 4, 0, 1);
    ins(0, 11, 11, 11);          iss(0, 4, 0, 10, 1, 10, 5, 0, 1);
    ins(0, 12, 10, 0);           iss(0, 11, 1, 11, 1, 11, 6, 0, 1);
    ins(0, 13, 0, 0);            iss(0, 5, 0, 0, 1, 12, 7, 1, 1);
                                 idle(1, 1);
                                 idle(1, 1);
    cmt(0, 1);                   idle(0, 1);
                                 iss(0, 0, 1, 0, 1, 13, 0, 1, 1);
    // mul_full blocks a div at the head until the queue fills
    cur.mf = 1; cmt(1, 2); ins(3, 14, 1, 2); idle(0, 1);
    cur.mf = 1; cmt(2, 0); ins(0, 15, 0, 0); idle(0, 1);
    cur.mf = 1; ins(0, 1, 14, 15); idle(0, 1);
    cur.mf = 1; ins(0, 3, 0, 0);   idle(0, 0);
    cur.mf = 1; ins(0, 4, 0, 0);   idle(0, 0);
                                 iss(3, 1, 1, 2, 1, 14, 1, 0, 1);
    cmt(3, 0);                   iss(0, 0, 1, 0, 1, 15, 2, 0, 1);
    cmt(4, 9);                   iss(0, 1, 0, 2, 0, 1, 3, 0, 1);
                                 iss(0, 0, 1, 0, 1, 3, 4, 1, 1);
    // Commit clears a source in the same cycle it is read
    cmt(5, 10); ins(0, 5, 11, 12); idle(0, 1);
    cmt(6, 11);
`ifdef ISSUE_BYPASS_EN
    iss(0, 11, 1, 7, 0, 5, 5, 0, 1);
`else
    iss(0, 6, 0, 7, 0, 5, 5, 0, 1);
`endif

    @(posedge clk1); #1;
    chk("reset.issue_valid", int'(bus.issue_valid), 0);
    chk("reset.in_ready", int'(bus.in_ready), 1);
    chk("reset.rob_full", int'(rob_full), 0);
    chk("reset.rob_ind", int'(bus.rob_ind), 0);
    chk("reset.func", int'(bus.func), 0);
    @(negedge clk1);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(posedge clk1); #1;
      chk($sformatf("v%0d.issue_valid", i), int'(bus.issue_valid), int'(tbl[i].e_iv));
      chk($sformatf("v%0d.in_ready", i), int'(bus.in_ready), int'(tbl[i].e_rdy));
      chk($sformatf("v%0d.rob_full", i), int'(rob_full), int'(tbl[i].e_rf));
      if (tbl[i].e_iv) begin
        chk($sformatf("v%0d.func", i), int'(bus.func), int'(tbl[i].e_f));
        chk($sformatf("v%0d.rs1", i), int'(bus.rs1), int'(tbl[i].e_rs1));
        chk($sformatf("v%0d.rs1_b", i), int'(bus.rs1_b), int'(tbl[i].e_b1));
        chk($sformatf("v%0d.rs2", i), int'(bus.rs2), int'(tbl[i].e_rs2));
        chk($sformatf("v%0d.rs2_b", i), int'(bus.rs2_b), int'(tbl[i].e_b2));
        chk($sformatf("v%0d.rd", i), int'(bus.rd), int'(tbl[i].e_rd));
        chk($sformatf("v%0d.rob_ind", i), int'(bus.rob_ind), int'(tbl[i].e_rob));
      end
      @(negedge clk1);
    end

    // Asynchronous reset while a bundle is valid
    cur = '0;
    drive(cur);
    rst = 1'b1;
    #1;
    chk("async_rst.issue_valid", int'(bus.issue_valid), 0);
    chk("async_rst.rd", int'(bus.rd), 0);
    chk("async_rst.in_ready", int'(bus.in_ready), 1);
    @(negedge clk1);
    rst = 1'b0;

    bus.in_valid = 1'b1; bus.in_func = 4'd0; bus.in_rd = 4'd2; bus.in_rs1 = 4'd7; bus.in_rs2 = 4'd7;
    @(posedge clk1); #1;
    bus.in_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 8 && got == 0; k++) begin
      if (bus.issue_valid) got = 1;
      else begin
        @(posedge clk1); #1;
      end
    end
    chk("post_rst.issue_seen", got, 1);
    chk("post_rst.rob_ind", int'(bus.rob_ind), 0);
    chk("post_rst.rs1", int'(bus.rs1), 7);
    chk("post_rst.rs1_b", int'(bus.rs1_b), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_cycle_rst.issue_valid", int'(bus.issue_valid), 0);
    chk("mid_cycle_rst.rd", int'(bus.rd), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
